// File: rtl/mul_adder_pkg.sv
// -----------------------------------------------------------------------------
// mul_adder_pkg
//   Shared CPU multiply/accumulate width constants.
//   MUL_OP_WIDTH   : width of one multiplier source operand
//   MUL_PROD_WIDTH : width of the full product (HI:LO)
//   MADD_WIDTH     : default datapath width of the multiply-accumulate adder
// -----------------------------------------------------------------------------
package mul_adder_pkg;

    localparam int unsigned MUL_OP_WIDTH   = 32;
    localparam int unsigned MUL_PROD_WIDTH = 2 * MUL_OP_WIDTH;
    localparam int unsigned MADD_WIDTH     = MUL_PROD_WIDTH;

endpackage : mul_adder_pkg

// File: rtl/mul_adder_cla.sv
// -----------------------------------------------------------------------------
// cla_adder
//   WIDTH-bit carry-lookahead adder built from 4-bit lookahead groups.
//   Level 1 resolves carries inside each group from the group carry-in;
//   level 2 derives each group carry-in from the previous group's
//   generate/propagate pair.
// Ports:
//   i_a, i_b : addends (WIDTH)
//   i_cin    : carry-in
//   o_sum    : i_a + i_b + i_cin modulo 2^WIDTH (carry-out discarded)
// -----------------------------------------------------------------------------
module cla_adder #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum
);

    // Datapath is padded up to a whole number of 4-bit groups.
    localparam int unsigned NG = (WIDTH + 3) / 4;
    localparam int unsigned WP = NG * 4;

    logic [WP-1:0] w_a;
    logic [WP-1:0] w_b;
    logic [WP-1:0] w_g;
    logic [WP-1:0] w_p;
    logic [WP-1:0] w_c;

    always_comb begin
        logic w_gc;
        logic w_gg;
        logic w_gp;

        w_a = '0;
        w_b = '0;
        w_a[WIDTH-1:0] = i_a;
        w_b[WIDTH-1:0] = i_b;
        w_g = w_a & w_b;
        w_p = w_a ^ w_b;
        w_c = '0;
        w_gc = i_cin;
        w_gg = 1'b0;
        w_gp = 1'b0;

        for (int unsigned k = 0; k < NG; k++) begin
            // level 1: carries into each bit of the group
            w_c[4*k]   = w_gc;
            w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_gc);
            w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+1] & w_p[4*k] & w_gc);
            w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                       | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_gc);

            // level 2: group generate/propagate feed the next group carry
            w_gg = w_g[4*k+3] | (w_p[4*k+3] & w_g[4*k+2])
                 | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                 | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
            w_gp = &w_p[4*k +: 4];
            w_gc = w_gg | (w_gp & w_gc);
        end

        o_sum = w_p[WIDTH-1:0] ^ w_c[WIDTH-1:0];
    end

endmodule : cla_adder

// File: rtl/mul_adder.sv
// -----------------------------------------------------------------------------
// mul_adder
//   Final stage of the multiplier: adds the carry-save product words A and B,
//   optionally accumulating into / subtracting from C_ (MADD/MSUB), and
//   registers the result. Latency 1, throughput 1 per cycle.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears res
//   A     : carry-save sum word of the product (WIDTH)
//   B     : carry-save carry word of the product, pre-aligned (WIDTH)
//   C_    : accumulator operand (WIDTH)
//   a_s   : 0 = C_ + P, 1 = C_ - P (only when en_c = 1)
//   en_c  : 0 = res <= P, 1 = combine with C_
//   res   : registered result (WIDTH)
// -----------------------------------------------------------------------------
module mul_adder
    import mul_adder_pkg::*;
#(
    parameter int unsigned WIDTH = MADD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C_,
    input  logic             a_s,
    input  logic             en_c,
    output logic [WIDTH-1:0] res
);

    logic             w_sub;
    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;
    logic [WIDTH-1:0] w_z;
    logic [WIDTH-1:0] w_csa_sum;
    logic [WIDTH-1:0] w_csa_carry;
    logic [WIDTH-1:0] w_cpa_sum;

    // Operand select. Subtraction is C_ + ~A + ~B + 2: the two +1 terms are
    // the CPA carry-in and a 1 dropped into the empty bit 0 of the shifted
    // carry word.
    always_comb begin
        w_sub = en_c & a_s;
        w_x   = w_sub ? ~A : A;
        w_y   = w_sub ? ~B : B;
        w_z   = en_c ? C_ : '0;
    end

    // 3:2 compression; majority bit WIDTH-1 would shift out and is dropped.
    always_comb begin
        w_csa_sum   = w_x ^ w_y ^ w_z;
        w_csa_carry = {(w_x[WIDTH-2:0] & w_y[WIDTH-2:0])
                     | (w_x[WIDTH-2:0] & w_z[WIDTH-2:0])
                     | (w_y[WIDTH-2:0] & w_z[WIDTH-2:0]), w_sub};
    end

    cla_adder #(
        .WIDTH (WIDTH)
    ) u_cla (
        .i_a   (w_csa_sum),
        .i_b   (w_csa_carry),
        .i_cin (w_sub),
        .o_sum (w_cpa_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res <= '0;
        end else begin
            res <= w_cpa_sum;
        end
    end

endmodule : mul_adder

// File: tb/tb_mul_adder.sv
module tb_mul_adder;

    localparam int unsigned W = 64;

    typedef struct {
        logic [W-1:0] exp;
        string        name;
    } sb_item_t;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] C_;
    logic         a_s;
    logic         en_c;
    logic [W-1:0] res;

    int unsigned checks;
    int unsigned errors;
    sb_item_t    sb[$];

    mul_adder #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .C_    (C_),
        .a_s   (a_s),
        .en_c  (en_c),
        .res   (res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain modular arithmetic on the product P = A + B.
    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] c, input logic en,
                                           input logic sub);
        logic [W-1:0] p;
        p = a + b;
        if (!en)     return p;
        else if (sub) return c - p;
        else         return c + p;
    endfunction

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 6))
            0:       return '0;
            1:       return '1;
            2:       return 64'h1;
            3:       return 64'h8000_0000_0000_0000;
            4:       return 64'h7fff_ffff_ffff_ffff;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: res=%h expected=%h", name, got, exp);
        end
    endtask

    // Called just after a falling edge: drive inputs and post the expected result.
    task automatic issue(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic en, input logic sub);
        sb_item_t it;
        A = a; B = b; C_ = c; en_c = en; a_s = sub;
        it.exp  = model(a, b, c, en, sub);
        it.name = name;
        sb.push_back(it);
    endtask

    // Monitor: one result per rising edge while anything is outstanding.
    initial begin
        sb_item_t it;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                it = sb.pop_front();
                check(it.name, res, it.exp);
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        A = '0; B = '0; C_ = '0; a_s = 1'b0; en_c = 1'b0;

        #3;
        check("reset_initial", res, '0);
        repeat (2) @(negedge clk);
        check("reset_hold", res, '0);

        @(negedge clk);
        rst_n = 1'b1;
        issue("madd_en0", 64'ha5a5a5a5a5a5a5a5, 64'h5a5a5a5a5a5a5a5a, '1, 1'b0, 1'b0);
        @(negedge clk);
        issue("madd_add_wrap", 64'ha5a5a5a5a5a5a5a5, 64'h5a5a5a5a5a5a5a5a, '1, 1'b1, 1'b0);
        @(negedge clk);
        issue("madd_sub_zero", 64'ha5a5a5a5a5a5a5a5, 64'h5a5a5a5a5a5a5a5a, '1, 1'b1, 1'b1);
        @(negedge clk);
        issue("sub_borrow", 64'h1, 64'h0, 64'h0, 1'b1, 1'b1);
        @(negedge clk);
        issue("carry_all", '1, 64'h1, 64'h1234, 1'b0, 1'b1);
        @(negedge clk);
        issue("carry_msb", 64'h7fff_ffff_ffff_ffff, 64'h1, '0, 1'b0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            issue("random", rand_op(), rand_op(), rand_op(), 1'($urandom), 1'($urandom));
        end

        // Mid-operation asynchronous reset.
        @(negedge clk);
        issue("pre_reset", 64'ha5a5a5a5a5a5a5a5, 64'h5a5a5a5a5a5a5a5a, '1, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", res, '0);
        @(negedge clk);
        A = 64'h1111; B = 64'h2222; en_c = 1'b0;
        @(posedge clk);
        #1;
        check("reset_hold_edge", res, '0);
        @(negedge clk);
        rst_n = 1'b1;
        issue("post_reset", 64'ha5a5a5a5a5a5a5a5, 64'h5a5a5a5a5a5a5a5a, '1, 1'b0, 1'b0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: outstanding=%0d required=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mul_adder
